sd_spi_engine: RTL and testbench
================================

Name: sd_spi_engine

Overview:
- Byte-level SPI master that sits directly below the SD-card protocol controller in the RK8E disk path.
- Accepts one command at a time: assert CS, deassert CS, or transfer a byte.
- Shifts one byte out on sdMOSI while capturing one byte from sdMISO, at a slow initialisation rate or a fast data rate.
- Drives the physical SD pins (sdCS, sdSCLK, sdMOSI) and reports completion with a one-cycle done pulse.

Parameters:
- SLOW_DIV, 63, SCLK half-period minus 1 in clk cycles for init rate (50 MHz / 128 ≈ 390 kHz).
- FAST_DIV, 1, SCLK half-period minus 1 in clk cycles for data rate (50 MHz / 4 = 12.5 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  IOCLR; synchronous abort
- spiOP  in  2  00 NOP, 01 CSL (assert CS), 10 CSH (deassert CS), 11 TRAN (byte transfer)
- spiSTART  in  1  command strobe; sampled only when spiBUSY=0
- spiFAST  in  1  1 = use FAST_DIV; sampled with spiSTART
- spiTXD  in  8  byte to transmit, MSB first; sampled with spiSTART
- spiRXD  out  8  last received byte; valid from the spiDONE cycle until the next TRAN completes
- spiBUSY  out  1  command in progress
- spiDONE  out  1  one-cycle pulse when a command completes
- sdMISO  in  1  SD data in
- sdMOSI  out  1  SD data out
- sdSCLK  out  1  SD clock
- sdCS  out  1  SD chip select, active low

Behaviour:
- Reset and clear values: sdCS=1, sdSCLK=0, sdMOSI=1, spiBUSY=0, spiDONE=0, spiRXD=8'h00, state IDLE.
- clear mid-transfer aborts immediately to the reset values; no spiDONE pulse is generated.
- SPI mode 0: SCLK idles low; MOSI changes on the falling edge (or at launch); MISO is sampled on the rising edge.
- States: IDLE, CSOP, SHIFT_LO, SHIFT_HI, FINISH.
- IDLE:
  - spiSTART with spiOP=CSL or CSH -> CSOP.
  - spiSTART with spiOP=TRAN -> SHIFT_LO.
  - spiSTART with spiOP=NOP -> spiDONE pulse next cycle, no pin activity.
  - spiSTART with spiBUSY=1 is ignored entirely; it is not queued.
- CSOP (one cycle):
  - sdCS is updated (CSL -> 0, CSH -> 1) on the cycle after the start.
  - spiDONE pulses that same cycle.
  - Returns to IDLE; spiBUSY is high only in the CSOP cycle.
- TRAN launch (start edge T):
  - Latch div = spiFAST ? FAST_DIV : SLOW_DIV.
  - Latch shift register = spiTXD.
  - Set bit counter = 7.
  - At T+1: sdMOSI = spiTXD[7], spiBUSY=1.
- Half-period counter: loads div and counts down; at 0 it toggles phase. Every half-period is div+1 clocks.
- SHIFT_LO -> SHIFT_HI:
  - sdSCLK rises.
  - Shift in sdMISO, sampled in the same cycle that SCLK rises; MSB first.
- SHIFT_HI -> SHIFT_LO:
  - sdSCLK falls.
  - Drive the next TX bit and decrement the bit counter.
  - After the 8th high phase, go to FINISH instead.
- FINISH (one cycle):
  - sdSCLK=0, sdMOSI=1.
  - spiRXD = assembled byte, spiDONE=1, spiBUSY=0.
  - Return to IDLE.
- Latency: spiSTART at T -> spiDONE at T+1+16*(div+1).
  - FAST_DIV=1: 33 cycles.
  - SLOW_DIV=63: 1025 cycles.
- A back-to-back spiSTART in the spiDONE cycle is accepted, because spiBUSY=0 in that cycle.
- sdMOSI=1 whenever no transfer is active, so idle bytes read as 0xFF to the card.
- spiFAST or spiTXD changing mid-transfer has no effect.
- sdCS is never altered by TRAN; CS state persists across transfers.
- Exactly 8 rising SCLK edges per TRAN; no glitch or extra edge on abort.

Test Plan:
- Reset held 3 cycles -> sdCS=1, sdSCLK=0, sdMOSI=1, spiBUSY=0, spiRXD=8'h00; no SCLK edges during 10 further idle cycles.
- CSL start -> sdCS=0 and spiDONE=1 one cycle later, spiBUSY high 1 cycle; then CSH start -> sdCS=1 one cycle later.
- TRAN, spiFAST=1, spiTXD=8'hA5, MISO model returning 8'h3C -> MOSI bits 1,0,1,0,0,1,0,1 stable at each rising edge, 8 rising edges, each SCLK high and low for 2 clocks, spiDONE at T+33, spiRXD=8'h3C.
- TRAN, spiFAST=0, spiTXD=8'hFF, MISO=0 -> SCLK high and low for 64 clocks each, spiDONE at T+1025, spiRXD=8'h00; a second spiSTART issued mid-transfer is ignored (exactly one spiDONE).
- clear asserted after the 3rd rising edge of a fast TRAN -> next cycle sdSCLK=0, sdCS=1, sdMOSI=1, spiBUSY=0, no spiDONE ever; a new TRAN of 8'h00 then completes normally in 33 cycles.
- Back-to-back TRANs of 8'h40 and 8'h95 (second start in the spiDONE cycle) -> 16 rising edges total, second spiDONE exactly 33 cycles after the first, sdCS stays 0 throughout.

Source files
------------

// File: rtl/sd_spi_engine.sv
// sd_spi_engine: byte-level SPI master (mode 0) for the SD-card data path.
// Accepts one command at a time: CS assert, CS deassert, NOP, or an 8-bit
// full-duplex transfer at a slow (init) or fast (data) SCLK rate.
module sd_spi_engine #(
  parameter int SLOW_DIV = 63,
  parameter int FAST_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [1:0] spiOP,
  input  logic       spiSTART,
  input  logic       spiFAST,
  input  logic [7:0] spiTXD,
  output logic [7:0] spiRXD,
  output logic       spiBUSY,
  output logic       spiDONE,
  input  logic       sdMISO,
  output logic       sdMOSI,
  output logic       sdSCLK,
  output logic       sdCS
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW      = (MAX_DIV > 0) ? $clog2(MAX_DIV + 1) : 1;
  localparam logic [CW-1:0] SLOW_L = CW'(SLOW_DIV);
  localparam logic [CW-1:0] FAST_L = CW'(FAST_DIV);

  typedef enum logic [2:0] {
    IDLE,
    CSOP,
    SHIFT_LO,
    SHIFT_HI,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_CSL  = 2'b01,
    OP_CSH  = 2'b10,
    OP_TRAN = 2'b11
  } op_t;

  state_t          state;
  op_t             op;
  logic [CW-1:0]   div;
  logic [CW-1:0]   half_cnt;
  logic [6:0]      tx_sr;     // remaining TX bits; bit 7 goes straight to sdMOSI at launch
  logic [7:0]      rx_sr;
  logic [2:0]      bit_cnt;

  assign op = op_t'(spiOP);

  // Command FSM, SCLK generation and shift datapath; all pin outputs registered.
  // FINISH accepts a new start exactly like IDLE, since spiBUSY is already low there.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state    <= IDLE;
      sdCS     <= 1'b1;
      sdSCLK   <= 1'b0;
      sdMOSI   <= 1'b1;
      spiBUSY  <= 1'b0;
      spiDONE  <= 1'b0;
      spiRXD   <= '0;
      div      <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
    end else begin
      spiDONE <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          state <= IDLE;
          if (spiSTART) begin
            case (op)
              OP_NOP: begin
                spiDONE <= 1'b1;
              end
              OP_CSL, OP_CSH: begin
                sdCS    <= (op == OP_CSH);
                spiDONE <= 1'b1;
                spiBUSY <= 1'b1;
                state   <= CSOP;
              end
              OP_TRAN: begin
                div      <= spiFAST ? FAST_L : SLOW_L;
                half_cnt <= spiFAST ? FAST_L : SLOW_L;
                tx_sr    <= spiTXD[6:0];
                sdMOSI   <= spiTXD[7];
                bit_cnt  <= 3'd7;
                spiBUSY  <= 1'b1;
                state    <= SHIFT_LO;
              end
              default: ;
            endcase
          end
        end
        CSOP: begin
          spiBUSY <= 1'b0;
          state   <= IDLE;
        end
        SHIFT_LO: begin
          if (half_cnt == '0) begin
            half_cnt <= div;
            sdSCLK   <= 1'b1;
            rx_sr    <= {rx_sr[6:0], sdMISO};
            state    <= SHIFT_HI;
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        SHIFT_HI: begin
          if (half_cnt == '0) begin
            half_cnt <= div;
            sdSCLK   <= 1'b0;
            if (bit_cnt == 3'd0) begin
              sdMOSI  <= 1'b1;
              spiRXD  <= rx_sr;
              spiDONE <= 1'b1;
              spiBUSY <= 1'b0;
              state   <= FINISH;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              sdMOSI  <= tx_sr[6];
              tx_sr   <= {tx_sr[5:0], 1'b0};
              state   <= SHIFT_LO;
            end
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_engine.sv
// Scoreboard bench for sd_spi_engine: stimulus pushes expected completions,
// a monitor pops and compares on every spiDONE and checks SCLK/MOSI behaviour.
module tb_sd_spi_engine;

  localparam int SLOW_DIV = 63;
  localparam int FAST_DIV = 1;

  logic       clk = 1'b0;
  logic       reset, clear, spiSTART, spiFAST, sdMISO;
  logic [1:0] spiOP;
  logic [7:0] spiTXD, spiRXD;
  logic       spiBUSY, spiDONE, sdMOSI, sdSCLK, sdCS;

  always #5 clk = ~clk;

  sd_spi_engine #(.SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV)) dut (
    .clk(clk), .reset(reset), .clear(clear), .spiOP(spiOP), .spiSTART(spiSTART),
    .spiFAST(spiFAST), .spiTXD(spiTXD), .spiRXD(spiRXD), .spiBUSY(spiBUSY),
    .spiDONE(spiDONE), .sdMISO(sdMISO), .sdMOSI(sdMOSI), .sdSCLK(sdSCLK), .sdCS(sdCS)
  );

  typedef struct {
    int unsigned done_cyc;
    logic [7:0]  rx;
    logic        cs;
    logic        busy;
    int unsigned half;
    int unsigned rises;
  } exp_t;

  exp_t        sbq[$];
  bit          bitq[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned rises = 0;
  int unsigned abort_gen = 0;
  bit          mon_en = 0;
  logic        clear_q = 1'b0;

  // card model: MISO byte presented MSB first, advancing on each SCLK fall
  logic [7:0] miso_byte = 8'hFF;
  int         fall_cnt = 0;
  int         fall_base = 0;
  int         miso_d;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) clear_q <= clear;
  always @(negedge sdSCLK) fall_cnt <= fall_cnt + 1;

  always_comb begin
    miso_d = fall_cnt - fall_base;
    sdMISO = 1'b1;
    if (miso_d >= 0 && miso_d < 8) sdMISO = miso_byte[7 - miso_d];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pin sanity every cycle, edge/timing checks, scoreboard pop on spiDONE
  initial begin
    logic        last_sclk;
    int unsigned run_len;
    int unsigned seen_gen;
    exp_t        e;
    bit          b;
    wait (mon_en);
    last_sclk = sdSCLK;
    run_len   = 0;
    seen_gen  = abort_gen;
    forever begin
      @(negedge clk);
      if (seen_gen != abort_gen) begin
        rises    = 0;
        seen_gen = abort_gen;
      end
      if (sdSCLK !== last_sclk) begin
        if (last_sclk == 1'b0) begin
          rises++;
          check("rise_expected", 32'(bitq.size() > 0), 32'd1);
          if (bitq.size() > 0) begin
            b = bitq.pop_front();
            check("mosi_at_rise", 32'(sdMOSI), 32'(b));
          end
          if (rises > 1 && sbq.size() > 0) check("sclk_low_len", run_len, sbq[0].half);
        end else begin
          if (!clear_q && sbq.size() > 0) check("sclk_high_len", run_len, sbq[0].half);
        end
        run_len   = 1;
        last_sclk = sdSCLK;
      end else begin
        run_len++;
      end
      if (!spiBUSY) check("idle_pins", {30'd0, sdSCLK, sdMOSI}, 32'd1);
      if (spiDONE) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("rxd", 32'(spiRXD), 32'(e.rx));
          check("cs_at_done", 32'(sdCS), 32'(e.cs));
          check("busy_at_done", 32'(spiBUSY), 32'(e.busy));
          check("rise_count", rises, e.rises);
        end
        rises = 0;
      end
    end
  end

  logic        model_cs = 1'b1;
  logic [7:0]  last_rx = 8'h00;

  // drive a start at the current negedge and record the expected completion
  task automatic issue(input logic [1:0] op, input logic fast, input logic [7:0] txd,
                       input logic [7:0] mbyte);
    exp_t        e;
    int unsigned div;
    spiSTART = 1'b1;
    spiOP    = op;
    spiFAST  = fast;
    spiTXD   = txd;
    div      = fast ? FAST_DIV : SLOW_DIV;
    if (op == 2'b01) model_cs = 1'b0;
    if (op == 2'b10) model_cs = 1'b1;
    e.cs    = model_cs;
    e.busy  = (op == 2'b01 || op == 2'b10);
    e.half  = 0;
    e.rises = 0;
    if (op == 2'b11) begin
      miso_byte = mbyte;
      fall_base = fall_cnt;
      last_rx   = mbyte;
      for (int i = 7; i >= 0; i--) bitq.push_back(txd[i]);
      e.half     = div + 1;
      e.rises    = 8;
      e.done_cyc = cyc + 1 + 16 * (div + 1);
    end else begin
      e.done_cyc = cyc + 1;
    end
    e.rx = last_rx;
    sbq.push_back(e);
  endtask

  // release start after one cycle, then wait (bounded) for spiDONE
  task automatic wait_done(input int unsigned budget);
    int unsigned n;
    @(negedge clk);
    spiSTART = 1'b0;
    n = 0;
    while (!spiDONE && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!spiDONE) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int unsigned n;
    logic [1:0]  op;
    reset = 1'b1; clear = 1'b0; spiSTART = 1'b0; spiOP = 2'b00; spiFAST = 1'b0; spiTXD = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs",   32'(sdCS),    32'd1);
    check("rst_sclk", 32'(sdSCLK),  32'd0);
    check("rst_mosi", 32'(sdMOSI),  32'd1);
    check("rst_busy", 32'(spiBUSY), 32'd0);
    check("rst_done", 32'(spiDONE), 32'd0);
    check("rst_rxd",  32'(spiRXD),  32'h00);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_edges", rises, 32'd0);

    // chip-select handling
    issue(2'b01, 1'b0, 8'h00, 8'h00);
    wait_done(5);
    check("cs_low", 32'(sdCS), 32'd0);
    @(negedge clk);
    check("csop_busy_one_cycle", 32'(spiBUSY), 32'd0);
    issue(2'b10, 1'b0, 8'h00, 8'h00);
    wait_done(5);
    check("cs_high", 32'(sdCS), 32'd1);
    @(negedge clk);
    issue(2'b00, 1'b0, 8'h00, 8'h00);
    wait_done(5);
    @(negedge clk);
    issue(2'b01, 1'b0, 8'h00, 8'h00);
    wait_done(5);
    @(negedge clk);

    // fast transfer
    issue(2'b11, 1'b1, 8'hA5, 8'h3C);
    wait_done(60);
    @(negedge clk);

    // slow transfer with a stray start and input changes mid-transfer
    issue(2'b11, 1'b0, 8'hFF, 8'h00);
    @(negedge clk);
    spiSTART = 1'b0;
    repeat (100) @(negedge clk);
    spiSTART = 1'b1; spiOP = 2'b11; spiFAST = 1'b1; spiTXD = 8'h12;
    wait_done(1100);
    spiFAST = 1'b0; spiTXD = 8'h00;
    repeat (3) @(negedge clk);

    // abort after the third rising edge
    issue(2'b11, 1'b1, 8'h5A, 8'hC3);
    @(negedge clk);
    spiSTART = 1'b0;
    n = 0;
    while (rises < 3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_rise3", 32'(rises >= 3), 32'd1);
    clear = 1'b1;
    sbq.delete();
    bitq.delete();
    abort_gen++;
    model_cs = 1'b1;
    last_rx  = 8'h00;
    @(negedge clk);
    clear = 1'b0;
    check("abort_sclk", 32'(sdSCLK),  32'd0);
    check("abort_cs",   32'(sdCS),    32'd1);
    check("abort_mosi", 32'(sdMOSI),  32'd1);
    check("abort_busy", 32'(spiBUSY), 32'd0);
    check("abort_rxd",  32'(spiRXD),  32'h00);
    repeat (40) @(negedge clk);
    issue(2'b11, 1'b1, 8'h00, 8'h81);
    wait_done(60);
    @(negedge clk);

    // back-to-back transfers with CS held low
    issue(2'b01, 1'b0, 8'h00, 8'h00);
    wait_done(5);
    @(negedge clk);
    issue(2'b11, 1'b1, 8'h40, 8'h6E);
    wait_done(60);
    issue(2'b11, 1'b1, 8'h95, 8'hD2);
    wait_done(60);

    // randomized command mix, sometimes back-to-back
    for (int k = 0; k < 30; k++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) op = 2'b11;
      issue(op, ($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom));
      wait_done(1100);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
